// File: rtl/zx_video_ula.sv
// zx_video_ula: Spectrum ULA-style colour video generator with VGA timing, screen RAM fetch and frame interrupt.
// Optional ZX_VIDEO_SCANLINE_EN halves the output level on odd active lines.
module zx_video_ula #(
  parameter int HA = 640,
  parameter int HFP = 16,
  parameter int HS = 96,
  parameter int HBP = 48,
  parameter int VA = 480,
  parameter int VFP = 11,
  parameter int VS = 2,
  parameter int VBP = 31,
  parameter int HB = 64,
  parameter int VB = 48,
  parameter logic [3:0] NORMAL_LEVEL = 4'hC,
  parameter logic [3:0] BRIGHT_LEVEL = 4'hF,
  parameter int INT_LEN = 64
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [2:0]  border,
  output logic [12:0] vga_addr,
  input  logic [7:0]  vga_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        n_int
);
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam logic [HW-1:0] H_END = HW'(HT - 1);
  localparam logic [HW-1:0] H_A = HW'(HA);
  localparam logic [HW-1:0] H_SS = HW'(HA + HFP);
  localparam logic [HW-1:0] H_SE = HW'(HA + HFP + HS);
  localparam logic [HW-1:0] H_PS = HW'(HB);
  localparam logic [HW-1:0] H_PE = HW'(HA - HB);
  localparam logic [HW-1:0] F_S = HW'(HB - 16);
  localparam logic [HW-1:0] F_E = HW'(HA - HB - 16);
  localparam logic [VW-1:0] V_END = VW'(VT - 1);
  localparam logic [VW-1:0] V_A = VW'(VA);
  localparam logic [VW-1:0] V_SS = VW'(VA + VFP);
  localparam logic [VW-1:0] V_SE = VW'(VA + VFP + VS);
  localparam logic [VW-1:0] V_PS = VW'(VB);
  localparam logic [VW-1:0] V_PE = VW'(VA - VB);

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic [VW-1:0] vrow;
  logic [4:0]    flash_cnt;
  logic [7:0]    shifter, bitmap_next, attr_next, attr_cur;
  logic [9:0]    int_cnt;
  logic [8:0]    slot;
  logic [3:0]    p;
  logic [4:0]    c;
  logic [7:0]    y;
  logic          paper_row, paper_col, fetch, active, in_paper;
  logic [2:0]    pix_col, col;
  logic [3:0]    base_lvl, lvl;

  assign paper_row = vc >= V_PS && vc < V_PE;
  assign paper_col = hc >= H_PS && hc < H_PE;
  assign fetch     = paper_row && hc >= F_S && hc < F_E;
  assign active    = hc < H_A && vc < V_A;
  assign in_paper  = paper_row && paper_col;
  // slot counts from the fetch window start, so c is the cell being fetched
  assign slot = 9'(hc) - 9'(HB - 16);
  assign p    = slot[3:0];
  assign c    = slot[8:4];
  assign vrow = vc - V_PS;
  assign y    = 8'(vrow >> 1);

  always_comb begin
    vga_addr = '0;
    if (paper_row)
      vga_addr = (fetch && p == 4'd1) ? {3'b110, y[7:3], c} : {y[7:6], y[2:0], y[5:3], c};
  end

  always_comb begin
    pix_col  = (shifter[7] ^ (attr_cur[7] & flash_cnt[4])) ? attr_cur[2:0] : attr_cur[5:3];
    col      = in_paper ? pix_col : border;
    base_lvl = (in_paper && attr_cur[6]) ? BRIGHT_LEVEL : NORMAL_LEVEL;
  end

`ifdef ZX_VIDEO_SCANLINE_EN
  assign lvl = vc[0] ? base_lvl >> 1 : base_lvl;
`else
  assign lvl = base_lvl;
`endif

  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      hc        <= '0;
      vc        <= '0;
      flash_cnt <= '0;
    end else begin
      hc <= (hc == H_END) ? '0 : hc + 1'b1;
      if (hc == H_END) vc <= (vc == V_END) ? '0 : vc + 1'b1;
      if (hc == H_END && vc == V_END) flash_cnt <= flash_cnt + 1'b1;
    end

  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      shifter     <= '0;
      bitmap_next <= '0;
      attr_next   <= '0;
      attr_cur    <= '0;
    end else begin
      if (fetch && p == 4'd1) bitmap_next <= vga_data;
      if (fetch && p == 4'd2) attr_next <= vga_data;
      if (fetch && p == 4'd15) begin
        shifter  <= bitmap_next;
        attr_cur <= attr_next;
      end else if (hc[0]) shifter <= {shifter[6:0], 1'b0};
    end

  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_de <= 1'b0;
    end else begin
      vga_r  <= (active && col[1]) ? lvl : '0;
      vga_g  <= (active && col[2]) ? lvl : '0;
      vga_b  <= (active && col[0]) ? lvl : '0;
      vga_hs <= !(hc >= H_SS && hc < H_SE);
      vga_vs <= !(vc >= V_SS && vc < V_SE);
      vga_de <= active;
    end

  // a trigger arriving while the pulse is low is ignored
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      n_int   <= 1'b1;
      int_cnt <= '0;
    end else if (n_int) begin
      if (hc == H_SS && vc == V_SS) begin
        n_int   <= 1'b0;
        int_cnt <= 10'(INT_LEN - 1);
      end
    end else if (int_cnt == '0) n_int <= 1'b1;
    else int_cnt <= int_cnt - 1'b1;
endmodule
